rssb_boot_loader: RTL and testbench
===================================

Name: rssb_boot_loader

Overview:
- Upstream stage of the 8-bit RSSB core.
- Accepts a byte stream over a valid/ready handshake and writes the program image into the unified 8-bit memory through a dedicated write port.
- Holds the core in reset until the image is fully written, then releases it.
- Sits between the host/serial deserializer and the core's memory system and reset input.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory word width.
- BASE_ADDR, 3, first load address; 0/1/2 are the core's PC/accumulator/zero aliases and are never written.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  upstream byte valid
- in_data  input  DATA_W  upstream byte
- in_ready  output  1  loader can accept a byte this cycle
- reload  input  1  single-cycle pulse; restart load from DONE or ERROR
- mem_we  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory write address
- mem_data  output  DATA_W  memory write data
- cpu_reset  output  1  reset to core, high until load complete
- done  output  1  image loaded, core running
- error  output  1  load aborted

Behaviour:
- Reset values:
  - state=LEN; in_ready=1; mem_we=0; mem_addr=0; mem_data=0.
  - cpu_reset=1; done=0; error=0.
  - Internal counters cleared.
- Handshake: a byte transfers on a rising edge with in_valid && in_ready. in_data is ignored otherwise.
- Frame format: length byte N, then N payload bytes (plus one checksum byte when CHECKSUM_EN).
- State LEN (in_ready=1):
  - On transfer, latch N and set next address = BASE_ADDR.
  - N==0 -> DONE (or CSUM when CHECKSUM_EN).
  - N > 2^ADDR_W - BASE_ADDR -> ERROR.
  - Otherwise -> LOAD.
- State LOAD (in_ready=1):
  - Each transfer registers mem_we=1, mem_addr=next address, mem_data=in_data for exactly the following cycle, then increments the address.
  - Back-to-back transfers produce back-to-back write strobes.
  - No address wrap is possible, by the LEN check.
  - After the Nth byte -> DONE (or CSUM).
- State CSUM (CHECKSUM_EN only, in_ready=1): one transfer; see Optional Feature.
- State DONE (in_ready=0):
  - cpu_reset=0, done=1.
  - First DONE cycle coincides with the final mem_we pulse; the core's first fetch occurs no earlier than the following edge.
- State ERROR (in_ready=0): cpu_reset=1, error=1.
- reload:
  - In DONE or ERROR: -> LEN next edge; cpu_reset=1 from that edge; done/error cleared.
  - In LEN/LOAD/CSUM: ignored.
- cpu_reset, done and error are decoded from the state register only (glitch-free).
- Asynchronous reset mid-load:
  - Returns to LEN immediately; any pending mem_we is dropped.
  - Already-written memory contents are not cleared.
- in_valid held low mid-frame: the loader waits indefinitely; there is no timeout.

Optional Feature:
- Macro: RSSB_BOOT_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum of all payload bytes (mod 256) is kept.
  - The trailing byte C is accepted in CSUM.
  - (sum + C) mod 256 == 0 -> DONE; else -> ERROR.
  - C is never written to memory.
- Undefined: no CSUM state and no sum register; the frame ends after the payload.

Decomposition:
- Package rssb_pkg:
  - state enum {LEN, LOAD, CSUM, DONE, ERROR}.
  - Constants ADDR_PC=0, ADDR_ACC=1, ADDR_ZERO=2, default BASE_ADDR.
- One sub-module is natural: rssb_load_counter, holding the address and remaining-count registers with load/decrement/zero flag.

Test Plan:
- Length 3, payload 0x10,0x20,0x30 streamed continuously -> three consecutive mem_we pulses at addresses 3,4,5 with those data; done=1 and cpu_reset=0 on the final pulse cycle.
- Same frame with in_valid toggling every other cycle -> identical writes, one per accepted byte, with gaps; no write when in_valid=0.
- Length 0 -> no mem_we; DONE one edge after the length byte; then a reload pulse -> LEN, cpu_reset=1.
- Length 254 (0xFE) -> ERROR, error=1, no writes; length 253 -> writes at addresses 3..255 with no wrap.
- Reset asserted after 2 of 4 payload bytes -> cpu_reset=1, state LEN, no further writes; a full new frame then loads correctly.
- CHECKSUM_EN: payload 0x01,0x02, checksum 0xFD -> DONE; checksum 0xFE -> ERROR; in both cases the checksum byte is never written.

Source files
------------

// File: rtl/rssb_pkg.sv
// -----------------------------------------------------------------------------
// rssb_pkg
// Shared types and constants for the RSSB boot loader.
//   state_t            : loader frame-sequencer states
//   ADDR_PC/ACC/ZERO   : memory-mapped core registers at the bottom of memory;
//                        the loader never writes them
//   BASE_ADDR_DEFAULT  : first address the program image is written to
//   is_alias_addr()    : true for an address that aliases a core register
// Optional feature macro used by the loader: RSSB_BOOT_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package rssb_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int unsigned ADDR_PC           = 32'd0;
  localparam int unsigned ADDR_ACC          = 32'd1;
  localparam int unsigned ADDR_ZERO         = 32'd2;
  localparam int unsigned BASE_ADDR_DEFAULT = 32'd3;

  // An address that overlaps the core's PC, accumulator or zero register.
  function automatic logic is_alias_addr(input int unsigned addr);
    return (addr == ADDR_PC) || (addr == ADDR_ACC) || (addr == ADDR_ZERO);
  endfunction

endpackage

// File: rtl/rssb_load_counter.sv
// -----------------------------------------------------------------------------
// rssb_load_counter
// Write-address and remaining-byte counters for the boot loader.
//   clock, reset : system clock, asynchronous active-high reset
//   i_load       : start of frame; address <= BASE_ADDR, remaining <= i_len
//   i_len        : frame length byte
//   i_step       : one payload byte written; address++, remaining--
//   o_addr       : address for the next payload byte
//   o_last       : the next payload byte is the final one of the frame
//                  (remaining count reaches zero after this step)
// -----------------------------------------------------------------------------
module rssb_load_counter #(
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 8,
  parameter int BASE_ADDR = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;

  // Address / remaining-count registers: load at frame start, step per payload byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr      <= {ADDR_W{1'b0}};
      r_remaining <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_addr      <= ADDR_W'(BASE_ADDR);
      r_remaining <= i_len;
    end else if (i_step) begin
      // Increment after the last legal address (all ones) wraps, but the
      // frame is finished by then so the wrapped value is never used.
      r_addr      <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      r_remaining <= r_remaining - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_addr      <= r_addr;
      r_remaining <= r_remaining;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rssb_boot_loader.sv
// -----------------------------------------------------------------------------
// rssb_boot_loader
// Receives a length-prefixed byte frame over valid/ready and writes the
// payload into the core's unified memory starting at BASE_ADDR, holding the
// core in reset until the whole image is in place.
//
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   in_valid/in_data      : upstream byte stream
//   in_ready              : loader accepts a byte this cycle (LEN/LOAD/CSUM)
//   reload                : single-cycle pulse, restarts from DONE or ERROR
//   mem_we/addr/data      : registered memory write port, one cycle per byte
//   cpu_reset             : core reset, low only in DONE
//   done / error          : image loaded / load aborted
//
// Optional feature: define RSSB_BOOT_CHECKSUM_EN to expect a trailing checksum
// byte C after the payload; the frame is accepted only when
// (sum(payload) + C) mod 2^DATA_W == 0. C is never written to memory.
// -----------------------------------------------------------------------------
module rssb_boot_loader
  import rssb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  // Largest payload that fits between BASE_ADDR and the top of memory.
  localparam logic [31:0] MAX_LEN = 32'((32'd1 << ADDR_W) - 32'(BASE_ADDR));

`ifdef RSSB_BOOT_CHECKSUM_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_CSUM;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

  state_t            r_state;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
`ifdef RSSB_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_csum_total;
`endif

  logic              w_xfer;
  logic              w_len_zero;
  logic              w_len_over;
  logic              w_load;
  logic              w_step;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;

  assign w_xfer     = in_valid && in_ready;
  assign w_len_zero = (in_data == {DATA_W{1'b0}});
  assign w_len_over = (32'(in_data) > MAX_LEN);
  assign w_load     = w_xfer && (r_state == ST_LEN);
  assign w_step     = w_xfer && (r_state == ST_LOAD);
`ifdef RSSB_BOOT_CHECKSUM_EN
  assign w_csum_total = r_sum + in_data;
`endif

  rssb_load_counter #(
    .ADDR_W    (ADDR_W),
    .CNT_W     (DATA_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_load_counter (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_len  (in_data),
    .i_step (w_step),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  // Frame sequencer: state, registered write port and running checksum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_LEN;
      r_mem_we   <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_mem_data <= {DATA_W{1'b0}};
`ifdef RSSB_BOOT_CHECKSUM_EN
      r_sum      <= {DATA_W{1'b0}};
`endif
    end else begin
      // Write strobe lasts exactly one cycle per accepted payload byte.
      r_mem_we <= 1'b0;
      case (r_state)
        ST_LEN: begin
          if (w_xfer) begin
`ifdef RSSB_BOOT_CHECKSUM_EN
            r_sum <= {DATA_W{1'b0}};
`endif
            if (w_len_over) begin
              r_state <= ST_ERROR;
            end else if (w_len_zero) begin
              r_state <= ST_AFTER_PAYLOAD;
            end else begin
              r_state <= ST_LOAD;
            end
          end else begin
            r_state <= ST_LEN;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_addr;
            r_mem_data <= in_data;
`ifdef RSSB_BOOT_CHECKSUM_EN
            r_sum      <= w_csum_total;
`endif
            // DONE is entered on the same edge that launches the final
            // write, so the core cannot fetch before that write lands.
            if (w_last) begin
              r_state <= ST_AFTER_PAYLOAD;
            end else begin
              r_state <= ST_LOAD;
            end
          end else begin
            r_state <= ST_LOAD;
          end
        end
`ifdef RSSB_BOOT_CHECKSUM_EN
        ST_CSUM: begin
          if (w_xfer) begin
            if (w_csum_total == {DATA_W{1'b0}}) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_ERROR;
            end
          end else begin
            r_state <= ST_CSUM;
          end
        end
`endif
        ST_DONE: begin
          if (reload) begin
            r_state <= ST_LEN;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_ERROR: begin
          if (reload) begin
            r_state <= ST_LEN;
          end else begin
            r_state <= ST_ERROR;
          end
        end
        // Any unreachable encoding parks the loader with the core held in reset.
        default: begin
          r_state <= ST_ERROR;
        end
      endcase
    end
  end

  // Status outputs come straight from the state register so they cannot glitch.
  assign in_ready  = (r_state == ST_LEN) || (r_state == ST_LOAD)
`ifdef RSSB_BOOT_CHECKSUM_EN
                     || (r_state == ST_CSUM)
`endif
                     ;
  assign cpu_reset = (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign error     = (r_state == ST_ERROR);

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

endmodule

// File: tb/tb_rssb_boot_loader.sv
module tb_rssb_boot_loader;
  import rssb_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_reset;
  logic       done;
  logic       error;

  int checks   = 0;
  int failures = 0;

  // Reference model state: expected write in the current cycle and frame status
  // (0 = still loading / waiting, 1 = image accepted, 2 = aborted).
  bit         mon_en       = 1'b0;
  bit         exp_we       = 1'b0;
  logic [7:0] exp_addr     = 8'd0;
  logic [7:0] exp_data     = 8'd0;
  int         status       = 0;
  bit         reload_noise = 1'b0;
  logic [7:0] pay_q[$];

  always #5 clock = ~clock;

  rssb_boot_loader dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every cycle, compare the write port and status against the model.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_we) begin
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
        chk("mem_data", {24'd0, mem_data}, {24'd0, exp_data});
        chk("alias_addr", {31'd0, is_alias_addr(32'(mem_addr))}, 32'd0);
      end
      chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, status != 1});
      chk("done",      {31'd0, done},      {31'd0, status == 1});
      chk("error",     {31'd0, error},     {31'd0, status == 2});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, status == 0});
    end
  end

  task automatic tick(input bit we, input logic [7:0] a, input logic [7:0] d);
    @(posedge clock);
    #1;
    exp_we   = we;
    exp_addr = a;
    exp_data = d;
  endtask

  // Present one byte after a random number of idle (in_valid=0) cycles.
  task automatic send(input logic [7:0] b, input int gmin, input int gmax,
                      input bit is_pay, input logic [7:0] a);
    int gap;
    gap = int'($urandom_range(gmax, gmin));
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      reload   = reload_noise ? 1'($urandom) : 1'b0;
      tick(1'b0, 8'd0, 8'd0);
    end
    in_valid = 1'b1;
    in_data  = b;
    reload   = reload_noise ? 1'($urandom) : 1'b0;
    tick(is_pay, a, b);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    reload   = 1'b0;
  endtask

  // Whole frame; payload from pay_q, padded with random bytes.
  task automatic run_frame(input int len, input int gmin, input int gmax, input bit bad_csum);
    logic [7:0] sum;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] tot;
    sum = 8'd0;
    send(8'(len), gmin, gmax, 1'b0, 8'd0);
    if (len > 256 - 3) begin
      status = 2;
      return;
    end
`ifdef RSSB_BOOT_CHECKSUM_EN
    status = 0;
`else
    status = (len == 0) ? 1 : 0;
`endif
    for (int i = 0; i < len; i++) begin
      b = (i < pay_q.size()) ? pay_q[i] : 8'($urandom);
      send(b, gmin, gmax, 1'b1, 8'(3 + i));
      sum = sum + b;
`ifndef RSSB_BOOT_CHECKSUM_EN
      if (i == len - 1) status = 1;
`endif
    end
`ifdef RSSB_BOOT_CHECKSUM_EN
    c   = 8'd0 - sum + {7'd0, bad_csum};
    send(c, gmin, gmax, 1'b0, 8'd0);
    tot = sum + c;
    status = (tot == 8'd0) ? 1 : 2;
`else
    c   = {7'd0, bad_csum};
    tot = c;
`endif
  endtask

  // Idle in DONE/ERROR with in_valid toggling randomly: nothing may be accepted.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      tick(1'b0, 8'd0, 8'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic reload_pulse();
    in_valid = 1'b0;
    reload   = 1'b1;
    tick(1'b0, 8'd0, 8'd0);
    reload   = 1'b0;
    status   = 0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    mon_en   = 1'b1;
    repeat (2) tick(1'b0, 8'd0, 8'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_data", {24'd0, mem_data}, 32'd0);
    reset = 1'b0;
    tick(1'b0, 8'd0, 8'd0);

    // Length 3, continuous stream.
    pay_q = '{8'h10, 8'h20, 8'h30};
    run_frame(3, 0, 0, 1'b0);
    idle(4);
    reload_pulse();

    // Same frame, in_valid low every other cycle.
    run_frame(3, 1, 1, 1'b0);
    idle(3);
    reload_pulse();

    // Empty image.
    pay_q.delete();
    run_frame(0, 0, 0, 1'b0);
    idle(2);
    reload_pulse();

    // Oversized lengths abort; largest legal length fills 3..255.
    run_frame(254, 0, 2, 1'b0);
    idle(2);
    reload_pulse();
    run_frame(255, 0, 0, 1'b0);
    idle(2);
    reload_pulse();
    run_frame(253, 0, 0, 1'b0);
    idle(2);
    reload_pulse();

    // Reset after 2 of 4 payload bytes; the pending write must be dropped.
    pay_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send(8'd4, 0, 0, 1'b0, 8'd0);
    status = 0;
    send(pay_q[0], 0, 0, 1'b1, 8'd3);
    send(pay_q[1], 0, 0, 1'b1, 8'd4);
    reset  = 1'b1;
    exp_we = 1'b0;
    #1;
    chk("midrst_we",        {31'd0, mem_we},    32'd0);
    chk("midrst_addr",      {24'd0, mem_addr},  32'd0);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    tick(1'b0, 8'd0, 8'd0);
    tick(1'b0, 8'd0, 8'd0);
    reset = 1'b0;
    tick(1'b0, 8'd0, 8'd0);
    run_frame(4, 0, 0, 1'b0);
    idle(2);
    reload_pulse();

`ifdef RSSB_BOOT_CHECKSUM_EN
    pay_q = '{8'h01, 8'h02};
    run_frame(2, 0, 1, 1'b0);
    idle(2);
    reload_pulse();
    run_frame(2, 0, 1, 1'b1);
    idle(2);
    reload_pulse();
`endif

    // Randomised frames with reload noise that must be ignored mid-frame.
    reload_noise = 1'b1;
    for (int f = 0; f < 12; f++) begin
      pay_q.delete();
      if (f % 4 == 3)
        run_frame(int'($urandom_range(255, 240)), 0, 1, 1'($urandom));
      else
        run_frame(int'($urandom_range(30, 1)), 0, 3, 1'($urandom));
      idle(int'($urandom_range(4, 1)));
      reload_pulse();
    end
    reload_noise = 1'b0;
    tick(1'b0, 8'd0, 8'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
